// File: rtl/mult_accum_ctrl_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiply-accumulate controller.
package mult_accum_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_DONE
  } state_t;

  localparam logic [3:0] SHIFT_0 = 4'd0;
  localparam logic [3:0] SHIFT_4 = 4'd4;
  localparam logic [3:0] SHIFT_8 = 4'd8;

  // Zero-extend an 8-bit partial product to 16 bits and place it at its weight.
  function automatic logic [15:0] place_pp(input logic [7:0] pp, input logic [3:0] sh);
    return {8'h00, pp} << sh;
  endfunction

endpackage

// File: rtl/mult_accum_ctrl_if.sv
// Request/result bundle between a requester and the multiply-accumulate controller.
interface mult_accum_ctrl_if;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8_out;
  logic        done_flag;
  logic        busy;

  modport master (output start, dataa, datab, input product8x8_out, done_flag, busy);
  modport slave  (input start, dataa, datab, output product8x8_out, done_flag, busy);
endinterface

// File: rtl/mult_accum_ctrl_mult_fsm.sv
// Sequencer: walks the four nibble partial products and decodes busy/done and datapath selects.
module mult_fsm
  import mult_accum_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_a,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_load,
  output logic       o_acc_en,
  output logic       o_sel_a_hi,
  output logic       o_sel_b_hi,
  output logic [3:0] o_shift
);

  state_t r_state;
  state_t w_next;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    w_next     = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_load     = 1'b0;
    o_acc_en   = 1'b0;
    o_sel_a_hi = 1'b0;
    o_sel_b_hi = 1'b0;
    o_shift    = SHIFT_0;
    case (r_state)
      ST_IDLE: begin
        o_load = i_start;
        if (i_start) w_next = ST_S0;
      end
      ST_S0: begin
        o_busy   = 1'b1;
        o_acc_en = 1'b1;
        w_next   = ST_S1;
      end
      ST_S1: begin
        o_busy     = 1'b1;
        o_acc_en   = 1'b1;
        o_sel_a_hi = 1'b1;
        o_shift    = SHIFT_4;
        w_next     = ST_S2;
      end
      ST_S2: begin
        o_busy     = 1'b1;
        o_acc_en   = 1'b1;
        o_sel_b_hi = 1'b1;
        o_shift    = SHIFT_4;
        w_next     = ST_S3;
      end
      ST_S3: begin
        o_busy     = 1'b1;
        o_acc_en   = 1'b1;
        o_sel_a_hi = 1'b1;
        o_sel_b_hi = 1'b1;
        o_shift    = SHIFT_8;
        w_next     = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        o_load = i_start;
        w_next = i_start ? ST_S0 : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mult_accum_ctrl.sv
// 8x8 unsigned multiplier built from four 4x4 partial products accumulated over four cycles.
module mult_accum_ctrl
  import mult_accum_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset_a,
  mult_accum_ctrl_if.slave bus
);

  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;

  logic        w_load;
  logic        w_acc_en;
  logic        w_sel_a_hi;
  logic        w_sel_b_hi;
  logic [3:0]  w_shift;
  logic        w_busy;
  logic        w_done;
  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [7:0]  w_pp;
  logic [15:0] w_term;

  mult_fsm u_fsm (
    .clk        (clk),
    .reset_a    (reset_a),
    .i_start    (bus.start),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_load     (w_load),
    .o_acc_en   (w_acc_en),
    .o_sel_a_hi (w_sel_a_hi),
    .o_sel_b_hi (w_sel_b_hi),
    .o_shift    (w_shift)
  );

  assign w_nib_a = w_sel_a_hi ? r_a[7:4] : r_a[3:0];
  assign w_nib_b = w_sel_b_hi ? r_b[7:4] : r_b[3:0];
  assign w_pp    = {4'h0, w_nib_a} * {4'h0, w_nib_b};
  assign w_term  = place_pp(w_pp, w_shift);

  // Operands are captured once at acceptance, so later input changes cannot leak in.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (w_load) begin
      r_a   <= bus.dataa;
      r_b   <= bus.datab;
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign bus.product8x8_out = r_acc;
  assign bus.done_flag      = w_done;
  assign bus.busy           = w_busy;

endmodule

// File: tb/tb_mult_accum_ctrl.sv
// Scoreboard bench: stimulus queues expected products, a monitor compares on each done pulse.
module tb_mult_accum_ctrl;

  logic clk = 1'b0;
  logic reset_a;
  always #5 clk = ~clk;

  mult_accum_ctrl_if bus_if ();

  mult_accum_ctrl dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_a === 1'b1 && bus_if.done_flag === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", {15'h0, bus_if.done_flag}, 16'h0000);
      else                   check("result", bus_if.product8x8_out, exp_q.pop_front());
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.dataa = a;
    bus_if.datab = b;
  endtask

  initial begin
    logic [15:0] acc_tbl[5];
    int          t1;
    int          t2;
    int          n_done;

    reset_a      = 1'b0;
    bus_if.start = 1'b0;
    bus_if.dataa = 8'h00;
    bus_if.datab = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_product", bus_if.product8x8_out, 16'h0000);
    check("rst_busy", {15'h0, bus_if.busy}, 16'h0000);
    check("rst_done", {15'h0, bus_if.done_flag}, 16'h0000);

    // FF*FF issued together with reset release: first edge after release accepts it.
    #2;
    reset_a      = 1'b1;
    bus_if.start = 1'b1;
    bus_if.dataa = 8'hFF;
    bus_if.datab = 8'hFF;
    exp_q.push_back(16'hFE01);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_if.start = 1'b0;
        bus_if.dataa = 8'h3C;
        bus_if.datab = 8'hA5;
      end
      check($sformatf("ff_busy_c%0d", k), {15'h0, bus_if.busy}, {15'h0, (k <= 4)});
      check($sformatf("ff_done_c%0d", k), {15'h0, bus_if.done_flag}, {15'h0, (k == 5)});
    end

    // 12*34: 2*4=08; +1*4<<4 -> 48; +2*3<<4 -> A8; +1*3<<8 -> 3A8.
    acc_tbl = '{16'h0000, 16'h0008, 16'h0048, 16'h00A8, 16'h03A8};
    issue(8'h12, 8'h34);
    exp_q.push_back(16'h03A8);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus_if.start = 1'b0;
      check($sformatf("acc_12x34_c%0d", k), bus_if.product8x8_out, acc_tbl[k-1]);
    end
    repeat (10) @(negedge clk);
    check("held_3a8", bus_if.product8x8_out, 16'h03A8);
    check("idle_busy", {15'h0, bus_if.busy}, 16'h0000);

    // 5A*3C with a stray start (dataa=0) during S1.
    issue(8'h5A, 8'h3C);
    exp_q.push_back(16'h1518);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) check($sformatf("ignore_busy_c%0d", k), {15'h0, bus_if.busy}, 16'h0001);
      if (k == 1) bus_if.start = 1'b0;
      if (k == 2) begin
        bus_if.start = 1'b1;
        bus_if.dataa = 8'h00;
      end
      if (k == 3) bus_if.start = 1'b0;
    end
    @(negedge clk);

    // 77*99 aborted by reset in S2; partial sum 3F + 3F0 = 42F just before.
    issue(8'h77, 8'h99);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_partial", bus_if.product8x8_out, 16'h042F);
    #2 reset_a = 1'b0;
    #1;
    check("abort_product", bus_if.product8x8_out, 16'h0000);
    check("abort_busy", {15'h0, bus_if.busy}, 16'h0000);
    check("abort_done", {15'h0, bus_if.done_flag}, 16'h0000);
    @(negedge clk);
    #2 reset_a = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_if.done_flag === 1'b1) n_done++;
    end
    check("abort_no_done", 16'(n_done), 16'd0);

    // Start held high: 0A*0B then 80*02, done pulses five cycles apart.
    issue(8'h0A, 8'h0B);
    exp_q.push_back(16'h006E);
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_if.dataa = 8'h80;
        bus_if.datab = 8'h02;
        exp_q.push_back(16'h0100);
      end
      if (k == 6) bus_if.start = 1'b0;
      if (bus_if.done_flag === 1'b1) begin
        if (t1 < 0)      t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    check("b2b_first_done", 16'(t1), 16'd5);
    check("b2b_spacing", 16'(t2 - t1), 16'd5);

    // Zero operand, then result must hold through idle cycles.
    issue(8'h00, 8'hC3);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.dataa = 8'h55;
    bus_if.datab = 8'h55;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("zero_hold_c%0d", k), bus_if.product8x8_out, 16'h0000);
    end

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
